sub16_pipe: RTL and testbench

SUB16_PIPE -- requirements
Module: sub16_pipe

---
 rtl/sub_pkg.sv | 13 +
 rtl/sub_slice.sv | 19 +
 rtl/sub16_pipe.sv | 94 +++++++++
 tb/tb_sub16_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the pipelined subtractor.
// Default operand width and the derived slice width.
package sub_pkg;

    localparam int N_DEF = 16;

    function automatic int slice_w(input int n);
        return n / 2;
    endfunction

    localparam int SLICE_W = slice_w(N_DEF);

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit subtract slice with borrow in/out.
// diff = x - y - bi; bo is set on unsigned underflow.
module sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] diff,
    output logic         bo
);

    logic [W:0] t;

    assign t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    assign diff = t[W-1:0];
    assign bo   = t[W];

endmodule

// File: rtl/sub16_pipe.sv
// Two-stage valid/ready subtractor: lower slice in stage 1,
// upper slice plus flags in stage 2.
module sub16_pipe
    import sub_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int H = slice_w(N);

    logic         s1_v;
    logic [H-1:0] s1_dlo;
    logic         s1_blo;
    logic [H-1:0] s1_ah;
    logic [H-1:0] s1_bh;

    logic [H-1:0] dlo;
    logic         blo;
    logic [H-1:0] dhi;
    logic         bhi;
    logic         ovf_n;
    logic         ld2;
    logic         acc;

    sub_slice #(.W(H)) u_lo (
        .x    (a[H-1:0]),
        .y    (b[H-1:0]),
        .bi   (bin),
        .diff (dlo),
        .bo   (blo)
    );

    sub_slice #(.W(H)) u_hi (
        .x    (s1_ah),
        .y    (s1_bh),
        .bi   (s1_blo),
        .diff (dhi),
        .bo   (bhi)
    );

    assign ld2      = s1_v && (!out_valid || out_ready);
    assign in_ready = !s1_v || ld2;
    assign acc      = in_valid && in_ready;

    // Overflow only when operand signs differ and result sign leaves a's.
    assign ovf_n = (s1_ah[H-1] != s1_bh[H-1]) && (dhi[H-1] != s1_ah[H-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (acc) begin
                s1_v <= 1'b1;
            end else if (ld2) begin
                s1_v <= 1'b0;
            end
            if (ld2) begin
                out_valid <= 1'b1;
                d         <= {dhi, s1_dlo};
                bout      <= bhi;
                ovf       <= ovf_n;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && acc) begin
            s1_dlo <= dlo;
            s1_blo <= blo;
            s1_ah  <= a[N-1:H];
            s1_bh  <= b[N-1:H];
        end
    end

endmodule

// File: tb/tb_sub16_pipe.sv
// Self-checking bench for sub16_pipe: directed corners plus
// randomized traffic scoreboarded against an arithmetic model.
module tb_sub16_pipe;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;

    sub16_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        int           acc;
    } item_t;

    typedef struct {
        logic [N-1:0] d;
        logic         bout;
        logic         ovf;
    } res_t;

    item_t q[$];
    int    cyc;
    int    last_cons;
    int    nvec;
    int    nerr;

    function automatic res_t model(input item_t it);
        res_t         r;
        logic [N-1:0] dd;
        dd     = it.a - it.b - N'(it.bin);
        r.d    = dd;
        r.bout = ({1'b0, it.a} < ({1'b0, it.b} + (N+1)'(it.bin)));
        r.ovf  = (it.a[N-1] != it.b[N-1]) && (dd[N-1] != it.a[N-1]);
        return r;
    endfunction

    // One clock cycle: drive, check at negedge, update model, advance.
    task automatic step(input logic iv, input logic [N-1:0] ia,
                        input logic [N-1:0] ib, input logic ibin,
                        input logic ordy, input string tag);
        logic  exp_ir;
        logic  exp_ov;
        int    vis;
        res_t  r;
        item_t it;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        @(negedge clk);
        exp_ir = !(q.size() == 2 && !ordy);
        exp_ov = 1'b0;
        if (q.size() > 0) begin
            vis    = (q[0].acc + 2 > last_cons + 1) ? q[0].acc + 2
                                                    : last_cons + 1;
            exp_ov = (vis <= cyc);
        end
        nvec++;
        if (in_ready !== exp_ir) begin
            nerr++;
            $display("FAIL %s in_ready cyc=%0d got=%b exp=%b",
                     tag, cyc, in_ready, exp_ir);
        end
        nvec++;
        if (out_valid !== exp_ov) begin
            nerr++;
            $display("FAIL %s out_valid cyc=%0d got=%b exp=%b",
                     tag, cyc, out_valid, exp_ov);
        end
        if (exp_ov) begin
            r = model(q[0]);
            nvec++;
            if (d !== r.d || bout !== r.bout || ovf !== r.ovf) begin
                nerr++;
                $display("FAIL %s result cyc=%0d got d=%h bout=%b ovf=%b exp d=%h bout=%b ovf=%b",
                         tag, cyc, d, bout, ovf, r.d, r.bout, r.ovf);
            end
            if (ordy) begin
                void'(q.pop_front());
                last_cons = cyc;
            end
        end
        if (iv && exp_ir) begin
            it.a   = ia;
            it.b   = ib;
            it.bin = ibin;
            it.acc = cyc;
            q.push_back(it);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, tag);
    endtask

    task automatic check_empty(input string tag);
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL %s drain got=%0d pending exp=0", tag, q.size());
        end
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h0001;
        bin       = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        cyc++;
        q.delete();
        last_cons = cyc - 10;
        nvec++;
        if (out_valid !== 1'b0 || d !== '0 || bout !== 1'b0 ||
            ovf !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL %s reset got ov=%b d=%h bout=%b ovf=%b ir=%b exp ov=0 d=0000 bout=0 ovf=0 ir=1",
                     tag, out_valid, d, bout, ovf, in_ready);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
        idle(3, "reset_idle");
        check_empty("reset");
    endtask

    task automatic test_directed();
        step(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, "d5m3");
        idle(3, "d5m3");
        step(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b1, "ripple");
        idle(3, "ripple");
        step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, "zero_bin");
        idle(3, "zero_bin");
        step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, "ovf");
        idle(3, "ovf");
        step(1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, "ovf_pos");
        idle(3, "ovf_pos");
        check_empty("directed");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'(16'h1000 * (i + 1)), 16'(i * 3), i[0], 1'b1, "b2b");
        idle(4, "b2b");
        check_empty("b2b");
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'(16'hA000 + i), 16'(16'h00F0 + i), 1'b1, 1'b0, "stall");
        idle(5, "stall_release");
        check_empty("stall");
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b0, "rst_fill");
        step(1'b1, 16'h5555, 16'h2222, 1'b0, 1'b0, "rst_fill");
        step(1'b1, 16'h6666, 16'h3333, 1'b0, 1'b0, "rst_fill");
        do_reset("rst_mid");
        idle(4, "rst_after");
        check_empty("rst_mid");
    endtask

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] c [4];
        c[0] = 16'h0000;
        c[1] = 16'hFFFF;
        c[2] = 16'h8000;
        c[3] = 16'h7FFF;
        if ($urandom_range(0, 4) == 0) return c[$urandom_range(0, 3)];
        return N'($urandom);
    endfunction

    task automatic test_random();
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) != 0, rand_op(), rand_op(),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 "random");
        idle(4, "random_drain");
        check_empty("random");
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        cyc       = 0;
        last_cons = -10;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
